// File: rtl/beat_sequencer.sv
// beat_sequencer: beat divider and song-position sequencer for RUN/PAUSE playback
//   clk, rst        : clock, synchronous active-high reset
//   mode            : game mode (IDLE=1 EDIT=2 DIFF=3 RUN=4 PAUSE=5 FINISH=6)
//   diff_speed      : clk cycles per beat, latched as max(diff_speed,2) at start
//   notes1, notes2  : note tracks, bit i = note at song position i
//   loop_en         : present only with BEAT_SEQ_LOOP_EN; wraps the song instead of draining
//   beat_tick       : one-cycle strobe per beat
//   note_valid      : note_out valid (beat in play or drain)
//   note_out        : {notes2[pos], notes1[pos]} on play beats, 0 otherwise
//   position        : current song index
//   active          : lead-in, play, paused or drain
//   finish          : registered one-cycle end-of-song pulse
module beat_sequencer #(
    parameter int SONG_LEN   = 32,
    parameter int LANE_LEN   = 7,
    parameter int LEAD_BEATS = 4,
    parameter int CNT_W      = 23
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  mode,
    input  logic [CNT_W-1:0]            diff_speed,
    input  logic [SONG_LEN-1:0]         notes1,
    input  logic [SONG_LEN-1:0]         notes2,
`ifdef BEAT_SEQ_LOOP_EN
    input  logic                        loop_en,
`endif
    output logic                        beat_tick,
    output logic                        note_valid,
    output logic [1:0]                  note_out,
    output logic [$clog2(SONG_LEN)-1:0] position,
    output logic                        active,
    output logic                        finish
);
    localparam int PW = $clog2(SONG_LEN);
    localparam int LW = $clog2(LEAD_BEATS + 1);
    localparam int DW = $clog2(LANE_LEN + 1);
    localparam logic [2:0] M_RUN   = 3'd4;
    localparam logic [2:0] M_PAUSE = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_LEADIN, S_PLAY, S_PAUSED, S_DRAIN, S_DONE} state_t;

    state_t           state, state_n, resume, resume_n, eff;
    logic [CNT_W-1:0] period, period_n, div, div_n;
    logic [PW-1:0]    pos_n;
    logic [LW-1:0]    lead, lead_n;
    logic [DW-1:0]    drain, drain_n;
    logic             finish_n, run, pause, wrap, tick, last, loop;

`ifdef BEAT_SEQ_LOOP_EN
    assign loop = loop_en;
`else
    assign loop = 1'b0;
`endif

    assign run   = mode == M_RUN;
    assign pause = mode == M_PAUSE;
    assign wrap  = div == period - CNT_W'(1);
    assign last  = position == PW'(SONG_LEN - 1);
    // A paused sequencer seeing RUN behaves as its resume state in that same
    // cycle, so a beat held off by pause fires on the first RUN cycle.
    assign eff   = (state == S_PAUSED && run) ? resume : state;
    assign tick  = (eff inside {S_LEADIN, S_PLAY, S_DRAIN}) && run && wrap;

    assign beat_tick  = tick;
    assign note_valid = tick && (eff == S_PLAY || eff == S_DRAIN);
    assign note_out   = (tick && eff == S_PLAY) ? {notes2[position], notes1[position]} : 2'b00;
    assign active     = state inside {S_LEADIN, S_PLAY, S_PAUSED, S_DRAIN};

    always_comb begin
        state_n  = eff;
        resume_n = resume;
        period_n = period;
        div_n    = div;
        pos_n    = position;
        lead_n   = lead;
        drain_n  = drain;
        finish_n = 1'b0;
        case (eff)
            S_IDLE: begin
                if (run) begin
                    state_n  = S_LEADIN;
                    period_n = diff_speed < CNT_W'(2) ? CNT_W'(2) : diff_speed;
                    div_n    = '0;
                    pos_n    = '0;
                    lead_n   = '0;
                end
            end
            S_LEADIN, S_PLAY, S_DRAIN: begin
                if (pause) begin
                    state_n  = S_PAUSED;
                    resume_n = eff;
                end else if (!run) begin
                    state_n = S_IDLE;
                    pos_n   = '0;
                end else begin
                    div_n = wrap ? '0 : div + CNT_W'(1);
                    if (tick && eff == S_LEADIN) begin
                        lead_n = lead + LW'(1);
                        if (lead == LW'(LEAD_BEATS - 1))
                            state_n = S_PLAY;
                    end else if (tick && eff == S_PLAY) begin
                        if (!last)
                            pos_n = position + PW'(1);
                        else if (loop)
                            pos_n = '0;
                        else begin
                            state_n = S_DRAIN;
                            drain_n = '0;
                        end
                    end else if (tick) begin
                        drain_n = drain + DW'(1);
                        if (drain == DW'(LANE_LEN - 1)) begin
                            finish_n = 1'b1;
                            state_n  = S_DONE;
                            pos_n    = '0;
                        end
                    end
                end
            end
            S_PAUSED: begin
                if (!pause) begin
                    state_n = S_IDLE;
                    pos_n   = '0;
                end
            end
            S_DONE: begin
                if (!run)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            resume   <= S_IDLE;
            period   <= '0;
            div      <= '0;
            position <= '0;
            lead     <= '0;
            drain    <= '0;
            finish   <= 1'b0;
        end else begin
            state    <= state_n;
            resume   <= resume_n;
            period   <= period_n;
            div      <= div_n;
            position <= pos_n;
            lead     <= lead_n;
            drain    <= drain_n;
            finish   <= finish_n;
        end
    end
endmodule
